// File: rtl/regdest_pkg.sv
// Shared definitions for the register-destination write sequencer.
// Contents: select-code localparams, FSM state encoding and the
// select-code to constant-index helper used by the decoder.
package regdest_pkg;

  localparam logic [3:0] SEL_FIELD     = 4'd0;
  localparam logic [3:0] SEL_CONST0    = 4'd1;
  localparam logic [3:0] SEL_CONST1    = 4'd2;
  localparam logic [3:0] SEL_CONST2    = 4'd3;
  localparam logic [3:0] SEL_CONST3    = 4'd4;
  localparam logic [3:0] SEL_CONST4    = 4'd5;
  localparam logic [3:0] SEL_CONST6    = 4'd6;
  localparam logic [3:0] SEL_CONST7    = 4'd7;
  localparam logic [3:0] SEL_CONST8    = 4'd8;
  localparam logic [3:0] SEL_CONST9    = 4'd9;
  localparam logic [3:0] SEL_CONST15   = 4'd10;
  localparam logic [3:0] SEL_CONST5    = 4'd11;
  localparam logic [3:0] SEL_MAX_LEGAL = 4'd11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Fixed destination index for the constant select codes (0 for others).
  function automatic logic [3:0] sel_const(input logic [3:0] sel);
    logic [3:0] idx;
    case (sel)
      SEL_CONST0:  idx = 4'd0;
      SEL_CONST1:  idx = 4'd1;
      SEL_CONST2:  idx = 4'd2;
      SEL_CONST3:  idx = 4'd3;
      SEL_CONST4:  idx = 4'd4;
      SEL_CONST6:  idx = 4'd6;
      SEL_CONST7:  idx = 4'd7;
      SEL_CONST8:  idx = 4'd8;
      SEL_CONST9:  idx = 4'd9;
      SEL_CONST15: idx = 4'd15;
      SEL_CONST5:  idx = 4'd5;
      default:     idx = 4'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/regdest_decode.sv
// Combinational destination resolver.
// Ports:
//   sel   in  4       destination select code
//   field in  17      instruction destination field
//   addr  out ADDR_W  resolved register index (constants truncated to ADDR_W)
//   legal out 1       select code is in the legal range
module regdest_decode
  import regdest_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic [3:0]        sel,
  input  logic [16:0]       field,
  output logic [ADDR_W-1:0] addr,
  output logic              legal
);

  // Only the low ADDR_W bits of the field ever name a register.
  logic unused_field_bits;
  assign unused_field_bits = ^field[16:ADDR_W];

  // Resolve the select code into an index and a legality flag.
  always_comb begin
    legal = (sel <= SEL_MAX_LEGAL);
    if (sel == SEL_FIELD) begin
      addr = field[ADDR_W-1:0];
    end else begin
      addr = ADDR_W'(sel_const(sel));
    end
  end

endmodule

// File: rtl/regdest_write_sequencer.sv
// Write sequencer between writeback and the register file.
// Accepts (select, field, data) requests, resolves the destination at
// accept time, queues {addr, data} in a DEPTH-entry FIFO and issues one
// register-file write per cycle, holding the write while rf_busy is high.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_valid/req_ready         request handshake (ready = FIFO not full)
//   req_sel/req_field/req_data  request payload
//   rf_busy                     register file stall
//   rf_we/rf_waddr/rf_wdata     register-file write port
//   pending_mask                registers with a queued or issuing write
//   sel_err                     one-cycle pulse for a dropped illegal code
//   idle                        FIFO empty and nothing issuing
module regdest_write_sequencer
  import regdest_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [3:0]               req_sel,
  input  logic [16:0]              req_field,
  input  logic [DATA_W-1:0]        req_data,
  input  logic                     rf_busy,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic [(1<<ADDR_W)-1:0]   pending_mask,
  output logic                     sel_err,
  output logic                     idle
);

  localparam int NREGS = 1 << ADDR_W;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [ADDR_W-1:0] dec_addr_s;
  logic              dec_legal_s;
  logic              accept_s;
  logic              push_s;
  logic              pop_s;
  logic              fifo_empty_s;
  logic [NREGS-1:0]  pending_s;
  logic [PTR_W-1:0]  slot_s;

  logic [ADDR_W-1:0] mem_addr_r [DEPTH];
  logic [DATA_W-1:0] mem_data_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  state_t            state_r;
  logic              rf_we_r;
  logic [ADDR_W-1:0] rf_waddr_r;
  logic [DATA_W-1:0] rf_wdata_r;
  logic              sel_err_r;

  regdest_decode #(
    .ADDR_W (ADDR_W)
  ) u_decode (
    .sel   (req_sel),
    .field (req_field),
    .addr  (dec_addr_s),
    .legal (dec_legal_s)
  );

  assign fifo_empty_s = (count_r == CNT_ZERO);
  assign req_ready    = (count_r != CNT_FULL);
  // Illegal codes complete the handshake but never reach the FIFO.
  assign accept_s     = req_valid && req_ready;
  assign push_s       = accept_s && dec_legal_s;

  // Pop whenever the output register is free or its write completes now.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      IDLE:        pop_s = !fifo_empty_s;
      ISSUE, HOLD: pop_s = !rf_busy && !fifo_empty_s;
      default:     pop_s = 1'b0;
    endcase
  end

  // FIFO storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr_r[i] <= {ADDR_W{1'b0}};
        mem_data_r[i] <= {DATA_W{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        mem_addr_r[wr_ptr_r] <= dec_addr_s;
        mem_data_r[wr_ptr_r] <= req_data;
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Issue FSM: loads the output register from the FIFO head and drives rf_we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      rf_we_r    <= 1'b0;
      rf_waddr_r <= {ADDR_W{1'b0}};
      rf_wdata_r <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (!fifo_empty_s) begin
            rf_waddr_r <= mem_addr_r[rd_ptr_r];
            rf_wdata_r <= mem_data_r[rd_ptr_r];
            rf_we_r    <= 1'b1;
            state_r    <= ISSUE;
          end else begin
            rf_we_r <= 1'b0;
            state_r <= IDLE;
          end
        end
        ISSUE, HOLD: begin
          if (rf_busy) begin
            rf_we_r <= 1'b1;
            state_r <= HOLD;
          end else if (!fifo_empty_s) begin
            rf_waddr_r <= mem_addr_r[rd_ptr_r];
            rf_wdata_r <= mem_data_r[rd_ptr_r];
            rf_we_r    <= 1'b1;
            state_r    <= ISSUE;
          end else begin
            rf_we_r <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          rf_we_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // One-cycle error pulse for an accepted illegal select code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_r <= 1'b0;
    end else begin
      sel_err_r <= accept_s && !dec_legal_s;
    end
  end

  // Pending-write mask: every occupied FIFO slot plus the issuing entry.
  always_comb begin
    pending_s = {NREGS{1'b0}};
    slot_s    = rd_ptr_r;
    for (int i = 0; i < DEPTH; i++) begin
      slot_s = rd_ptr_r + PTR_W'(i);
      if (CNT_W'(i) < count_r) begin
        pending_s[mem_addr_r[slot_s]] = 1'b1;
      end else begin
        pending_s = pending_s;
      end
    end
    if (state_r != IDLE) begin
      pending_s[rf_waddr_r] = 1'b1;
    end else begin
      pending_s = pending_s;
    end
  end

  assign pending_mask = pending_s;
  assign rf_we        = rf_we_r;
  assign rf_waddr     = rf_waddr_r;
  assign rf_wdata     = rf_wdata_r;
  assign sel_err      = sel_err_r;
  assign idle         = fifo_empty_s && (state_r == IDLE);

endmodule
